// File: rtl/fft_ctrl_pkg.sv
// Shared types, defaults and helpers for FFT stage control logic.
package fft_ctrl_pkg;

  localparam int DEF_NUM_INPUTS_PER_PATH = 32;
  localparam int DEF_DELAY_CYCLES        = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stage_state_t;

  // Width of a counter that indexes n items (at least one bit).
  function automatic int cnt_w_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag.
// It saturates at MAX, so a phase ends on the flag instead of wrapping.
module mod_counter #(
  parameter int           W   = 5,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == MAX);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/r2mdc_stage_sequencer.sv
// Frame sequencer for one R2MDC stage: pair counting, commutator select,
// delay-memory strobes/addresses, butterfly valid and status pulses.
module r2mdc_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter  int NUM_INPUTS_PER_PATH = DEF_NUM_INPUTS_PER_PATH,
  parameter  int DELAY_CYCLES        = DEF_DELAY_CYCLES,
  localparam int CNT_W               = cnt_w_of(NUM_INPUTS_PER_PATH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] cntr_IFFT_input_pairs,
  output logic             cm_swap,
  output logic             dly_wr_en,
  output logic [CNT_W-1:0] dly_wr_addr,
  output logic             dly_rd_en,
  output logic [CNT_W-1:0] dly_rd_addr,
  output logic             bf_valid,
  output logic             busy,
  output logic             frame_done,
  output logic             start_err,
  output logic             in_err
);

  localparam int               SWAP_BIT = $clog2(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS_PER_PATH - 1);
  localparam logic [CNT_W-1:0] D_IDX    = CNT_W'(DELAY_CYCLES);

  stage_state_t     state_q, state_d;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             wr_tc, rd_tc;
  logic             cnt_clr, accept, rd_inc;
  logic             bf_valid_q, frame_done_q, start_err_q, in_err_q;

  mod_counter #(.W(CNT_W), .MAX(LAST_IDX)) u_wr_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr_i (cnt_clr),
    .en_i  (accept),
    .cnt_o (wr_cnt),
    .tc_o  (wr_tc)
  );

  mod_counter #(.W(CNT_W), .MAX(LAST_IDX)) u_rd_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr_i (cnt_clr),
    .en_i  (rd_inc),
    .cnt_o (rd_cnt),
    .tc_o  (rd_tc)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    cm_swap  = 1'b0;
    accept   = 1'b0;
    rd_inc   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        cm_swap  = wr_cnt[SWAP_BIT];
        accept   = in_valid;
        // Read j is issued alongside write j+D, keeping the delay exactly D pairs.
        rd_inc   = in_valid && (wr_cnt >= D_IDX);
        if (in_valid && wr_tc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_inc = 1'b1;
        if (rd_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dly_wr_en             = accept;
  assign dly_wr_addr           = wr_cnt;
  assign dly_rd_en             = rd_inc;
  assign dly_rd_addr           = rd_cnt;
  assign cntr_IFFT_input_pairs = wr_cnt;
  assign busy                  = (state_q != IDLE);
  assign bf_valid              = bf_valid_q;
  assign frame_done            = frame_done_q;
  assign start_err             = start_err_q;
  assign in_err                = in_err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      bf_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      start_err_q  <= 1'b0;
      in_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      bf_valid_q   <= rd_inc;
      frame_done_q <= (state_q == DRAIN) && rd_tc;
      start_err_q  <= start && (state_q != IDLE);
      in_err_q     <= in_valid && (state_q != LOAD);
    end
  end

endmodule
